// File: rtl/writeback_unit.sv
// Writeback stage: two per-source result FIFOs merged onto one register-file write port,
// with a forwarding bus per source showing the youngest pending result of that source.

module writeback_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [4:0]  push_addr,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [4:0]  head_addr,
    output logic [31:0] head_data,
    output logic [4:0]  tail_addr,
    output logic [31:0] tail_data,
    output logic        not_empty,
    output logic        full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] tail_ptr;
    logic [CW-1:0] count;

    assign not_empty = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign tail_ptr  = wr_ptr - PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: nothing is visible unless count says it is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        head_addr = '0;
        head_data = '0;
        tail_addr = '0;
        tail_data = '0;
        if (not_empty) begin
            head_addr = addr_mem[rd_ptr];
            head_data = data_mem[rd_ptr];
            tail_addr = addr_mem[tail_ptr];
            tail_data = data_mem[tail_ptr];
        end
    end
endmodule

module writeback_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        func_valid,
    output logic        func_ready,
    input  logic [4:0]  func_addr,
    input  logic [31:0] func_data,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [4:0]  data_addr,
    input  logic [31:0] data_data,
    output logic        result_enable,
    output logic [4:0]  result_addr,
    output logic [31:0] result,
    output logic [4:0]  result_addr_func,
    output logic [31:0] result_func,
    output logic [4:0]  result_addr_data,
    output logic [31:0] result_data,
    output logic        idle
);
    logic        func_push, data_push;
    logic        func_pop, data_pop;
    logic        func_ne, data_ne;
    logic        func_full, data_full;
    logic [4:0]  func_head_addr, data_head_addr;
    logic [31:0] func_head_data, data_head_data;
    logic        last;
    logic        contested;
    logic        pick_data;

    // Handshake: a transfer happens at posedge when valid && ready; ready never
    // depends on a same-cycle pop, and register 0 results are accepted but dropped.
    assign func_ready = !rst && !func_full;
    assign data_ready = !rst && !data_full;
    assign func_push  = func_valid && func_ready && (func_addr != 5'd0);
    assign data_push  = data_valid && data_ready && (data_addr != 5'd0);

    // last=1 means data won the most recent contest, so func gets the next one.
    assign contested = func_ne && data_ne;
    assign pick_data = data_ne && (!func_ne || !last);
    assign data_pop  = pick_data;
    assign func_pop  = func_ne && !pick_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b0;
        end else if (contested) begin
            last <= pick_data;
        end
    end

    always_comb begin
        result_enable = func_ne || data_ne;
        result_addr   = '0;
        result        = '0;
        if (pick_data) begin
            result_addr = data_head_addr;
            result      = data_head_data;
        end else if (func_ne) begin
            result_addr = func_head_addr;
            result      = func_head_data;
        end
    end

    assign idle = !func_ne && !data_ne;

    writeback_fifo #(.DEPTH(DEPTH)) u_func_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (func_push),
        .push_addr (func_addr),
        .push_data (func_data),
        .pop       (func_pop),
        .head_addr (func_head_addr),
        .head_data (func_head_data),
        .tail_addr (result_addr_func),
        .tail_data (result_func),
        .not_empty (func_ne),
        .full      (func_full)
    );

    writeback_fifo #(.DEPTH(DEPTH)) u_data_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (data_push),
        .push_addr (data_addr),
        .push_data (data_data),
        .pop       (data_pop),
        .head_addr (data_head_addr),
        .head_data (data_head_data),
        .tail_addr (result_addr_data),
        .tail_data (result_data),
        .not_empty (data_ne),
        .full      (data_full)
    );
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.

module tb_writeback_unit;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        func_valid, func_ready;
    logic [4:0]  func_addr;
    logic [31:0] func_data;
    logic        data_valid, data_ready;
    logic [4:0]  data_addr;
    logic [31:0] data_data;
    logic        result_enable;
    logic [4:0]  result_addr;
    logic [31:0] result;
    logic [4:0]  result_addr_func, result_addr_data;
    logic [31:0] result_func, result_data;
    logic        idle;

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .func_valid       (func_valid),
        .func_ready       (func_ready),
        .func_addr        (func_addr),
        .func_data        (func_data),
        .data_valid       (data_valid),
        .data_ready       (data_ready),
        .data_addr        (data_addr),
        .data_data        (data_data),
        .result_enable    (result_enable),
        .result_addr      (result_addr),
        .result           (result),
        .result_addr_func (result_addr_func),
        .result_func      (result_func),
        .result_addr_data (result_addr_data),
        .result_data      (result_data),
        .idle             (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pending results per source as {addr, data}, oldest first.
    logic [36:0] fq[$];
    logic [36:0] dq[$];
    logic        data_won_last = 1'b0;
    logic        model_ok = 1'b0;

    function automatic logic m_data_turn();
        if (dq.size() == 0) return 1'b0;
        if (fq.size() == 0) return 1'b1;
        return !data_won_last;
    endfunction

    always @(posedge clk) begin
        logic f_acc, d_acc;
        if (rst) begin
            fq.delete();
            dq.delete();
            data_won_last = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            f_acc = func_valid && (fq.size() < DEPTH);
            d_acc = data_valid && (dq.size() < DEPTH);
            if (fq.size() != 0 || dq.size() != 0) begin
                if (m_data_turn()) begin
                    if (fq.size() != 0) data_won_last = 1'b1;
                    void'(dq.pop_front());
                end else begin
                    if (dq.size() != 0) data_won_last = 1'b0;
                    void'(fq.pop_front());
                end
            end
            if (f_acc && func_addr != 5'd0) fq.push_back({func_addr, func_data});
            if (d_acc && data_addr != 5'd0) dq.push_back({data_addr, data_data});
        end
    end

    always @(negedge clk) begin
        logic [36:0] w, ft, dt;
        if (model_ok) begin
            w  = '0;
            ft = (fq.size() != 0) ? fq[$] : '0;
            dt = (dq.size() != 0) ? dq[$] : '0;
            if (m_data_turn())          w = dq[0];
            else if (fq.size() != 0)    w = fq[0];
            chk("m_func_ready", {31'd0, func_ready}, {31'd0, !rst && fq.size() < DEPTH});
            chk("m_data_ready", {31'd0, data_ready}, {31'd0, !rst && dq.size() < DEPTH});
            chk("m_result_enable", {31'd0, result_enable}, {31'd0, fq.size() != 0 || dq.size() != 0});
            chk("m_result_addr", {27'd0, result_addr}, {27'd0, w[36:32]});
            chk("m_result", result, w[31:0]);
            chk("m_fwd_func_addr", {27'd0, result_addr_func}, {27'd0, ft[36:32]});
            chk("m_fwd_func_data", result_func, ft[31:0]);
            chk("m_fwd_data_addr", {27'd0, result_addr_data}, {27'd0, dt[36:32]});
            chk("m_fwd_data_data", result_data, dt[31:0]);
            chk("m_idle", {31'd0, idle}, {31'd0, fq.size() == 0 && dq.size() == 0});
        end
    end

    logic [4:0]  wlog[$];
    logic [31:0] f7log[$];
    logic        fr[20];
    logic        dr[20];

    initial begin
        int fi, di, n;
        logic fa, da;
        logic [4:0] exp_order[8];
        exp_order = '{5'd11, 5'd1, 5'd12, 5'd2, 5'd13, 5'd3, 5'd14, 5'd4};

        rst = 1'b1;
        func_valid = 1'b0; func_addr = '0; func_data = '0;
        data_valid = 1'b0; data_addr = '0; data_data = '0;
        tick();
        @(negedge clk);
        chk("reset_func_ready", {31'd0, func_ready}, 32'd0);
        chk("reset_data_ready", {31'd0, data_ready}, 32'd0);
        chk("reset_result_enable", {31'd0, result_enable}, 32'd0);
        tick();
        rst = 1'b0;

        // Single func result
        func_valid = 1'b1; func_addr = 5'd5; func_data = 32'hDEADBEEF;
        @(negedge clk);
        tick();
        func_valid = 1'b0;
        @(negedge clk);
        chk("single_en", {31'd0, result_enable}, 32'd1);
        chk("single_addr", {27'd0, result_addr}, 32'd5);
        chk("single_data", result, 32'hDEADBEEF);
        chk("single_fwd_addr", {27'd0, result_addr_func}, 32'd5);
        chk("single_fwd_data", result_func, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        chk("single_after_en", {31'd0, result_enable}, 32'd0);
        chk("single_after_addr", {27'd0, result_addr}, 32'd0);
        chk("single_after_fwd", {27'd0, result_addr_func}, 32'd0);
        chk("single_after_idle", {31'd0, idle}, 32'd1);
        tick();

        // Contention: func r1..r4, data r11..r14
        fi = 1; di = 1; n = 0;
        while ((fi <= 4 || di <= 4) && n < 20) begin
            func_valid = (fi <= 4); func_addr = 5'(fi); func_data = 32'(100 + fi);
            data_valid = (di <= 4); data_addr = 5'(10 + di); data_data = 32'(200 + di);
            @(negedge clk);
            fr[n] = func_ready;
            dr[n] = data_ready;
            fa = func_valid && func_ready;
            da = data_valid && data_ready;
            if (result_enable) wlog.push_back(result_addr);
            tick();
            if (fa) fi++;
            if (da) di++;
            n++;
        end
        chk("contention_budget", 32'(n < 20), 32'd1);
        func_valid = 1'b0; data_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (result_enable) wlog.push_back(result_addr);
            tick();
        end
        chk("contention_count", wlog.size(), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("contention_order_%0d", i),
                (i < wlog.size()) ? {27'd0, wlog[i]} : 32'hFFFF, {27'd0, exp_order[i]});
        chk("full_func_ready_c", {31'd0, fr[2]}, 32'd0);
        chk("full_func_ready_d", {31'd0, fr[3]}, 32'd1);
        chk("full_data_ready_d", {31'd0, dr[3]}, 32'd0);
        chk("full_data_ready_e", {31'd0, dr[4]}, 32'd1);

        // x0 discard
        data_valid = 1'b1; data_addr = 5'd0; data_data = 32'h1234;
        @(negedge clk);
        chk("x0_accept_ready", {31'd0, data_ready}, 32'd1);
        tick();
        data_valid = 1'b0;
        @(negedge clk);
        chk("x0_en", {31'd0, result_enable}, 32'd0);
        chk("x0_fwd_addr", {27'd0, result_addr_data}, 32'd0);
        chk("x0_fwd_data", result_data, 32'd0);
        chk("x0_idle", {31'd0, idle}, 32'd1);
        tick();

        // Forwarding youngest: r7=1 then r7=2 behind data traffic
        data_valid = 1'b1; data_addr = 5'd20; data_data = 32'h20;
        @(negedge clk);
        tick();
        data_addr = 5'd21; data_data = 32'h21;
        func_valid = 1'b1; func_addr = 5'd7; func_data = 32'h1;
        @(negedge clk);
        tick();
        data_valid = 1'b0;
        func_data = 32'h2;
        @(negedge clk);
        if (result_enable && result_addr == 5'd7) f7log.push_back(result);
        tick();
        func_valid = 1'b0;
        @(negedge clk);
        chk("fwd_young_addr", {27'd0, result_addr_func}, 32'd7);
        chk("fwd_young_data", result_func, 32'h2);
        repeat (5) begin
            if (result_enable && result_addr == 5'd7) f7log.push_back(result);
            tick();
            @(negedge clk);
        end
        tick();
        chk("fwd_write_count", f7log.size(), 32'd2);
        if (f7log.size() == 2) begin
            chk("fwd_write_first", f7log[0], 32'h1);
            chk("fwd_write_second", f7log[1], 32'h2);
        end

        // Reset mid-stream with 3 entries pending
        func_valid = 1'b1; func_addr = 5'd1; func_data = 32'hA1;
        data_valid = 1'b1; data_addr = 5'd2; data_data = 32'hA2;
        @(negedge clk);
        tick();
        func_addr = 5'd3; func_data = 32'hA3;
        data_addr = 5'd4; data_data = 32'hA4;
        @(negedge clk);
        tick();
        func_valid = 1'b0; data_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_func_ready", {31'd0, func_ready}, 32'd0);
        chk("rst_cycle_data_ready", {31'd0, data_ready}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_en", {31'd0, result_enable}, 32'd0);
        chk("post_rst_fwd_func", {27'd0, result_addr_func}, 32'd0);
        chk("post_rst_fwd_data", {27'd0, result_addr_data}, 32'd0);
        chk("post_rst_idle", {31'd0, idle}, 32'd1);
        chk("post_rst_ready", {31'd0, func_ready}, 32'd1);
        tick();
        func_valid = 1'b1; func_addr = 5'd5; func_data = 32'hB5;
        data_valid = 1'b1; data_addr = 5'd6; data_data = 32'hB6;
        @(negedge clk);
        tick();
        func_valid = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_contest_en", {31'd0, result_enable}, 32'd1);
        chk("post_rst_contest_data", {27'd0, result_addr}, 32'd6);
        tick();

        // Randomized traffic with occasional reset
        for (int c = 0; c < 3000; c++) begin
            func_valid = ($urandom_range(0, 3) != 0);
            func_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            func_data  = $urandom;
            data_valid = ($urandom_range(0, 2) != 0);
            data_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            data_data  = $urandom;
            rst        = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            tick();
        end
        rst = 1'b0; func_valid = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
